// File: rtl/timer_pkg.sv
// Shared register-map constants for the memory-mapped timer bank.
package timer_pkg;

    // Per-channel register offsets within a CH_STRIDE window
    localparam logic [3:0] OFF_TH    = 4'h0;
    localparam logic [3:0] OFF_TL    = 4'h4;
    localparam logic [3:0] OFF_TCON  = 4'h8;
    localparam logic [3:0] OFF_PRESC = 4'hC;

    // Global register offsets, relative to the end of the channel windows
    localparam logic [3:0] OFF_IRQ_STATUS = 4'h0;
    localparam logic [3:0] OFF_IRQ_MASK   = 4'h4;

    // TCON bit positions
    localparam int unsigned TCON_EN      = 0;
    localparam int unsigned TCON_IE      = 1;
    localparam int unsigned TCON_ONESHOT = 2;
    localparam int unsigned TCON_PEND    = 3;

    localparam int unsigned CH_STRIDE = 16;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: reload/count registers, control bits, prescaler.
// ovf_irq_o pulses combinationally in the cycle whose closing edge overflows.
module timer_channel
    import timer_pkg::*;
#(
    parameter int unsigned W          = 32,
    parameter logic [31:0] RESET_LOAD = 32'hFFFF_F800
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [31:0]  wdata_i,
    input  logic         we_th_i,
    input  logic         we_tl_i,
    input  logic         we_tcon_i,
    input  logic         we_presc_i,
    input  logic         clear_en_ack_i,
    output logic [W-1:0] th_o,
    output logic [W-1:0] tl_o,
    output logic [2:0]   tcon_o,
    output logic [15:0]  presc_o,
    output logic         ovf_irq_o
);

    localparam logic [W-1:0] LoadRst = RESET_LOAD[W-1:0];

    logic [W-1:0] th_q, th_d;
    logic [W-1:0] tl_q, tl_d;
    logic [2:0]   tcon_q, tcon_d;
    logic [15:0]  presc_q, presc_d;
    logic [15:0]  pc_q, pc_d;
    logic         tick;

    assign tick      = tcon_q[TCON_EN] && (pc_q == presc_q);
    assign ovf_irq_o = tick && (tl_q == '1);

    assign th_o    = th_q;
    assign tl_o    = tl_q;
    assign tcon_o  = tcon_q;
    assign presc_o = presc_q;

    // Next state: CPU writes take priority over count, reload and one-shot disable
    always_comb begin
        th_d    = th_q;
        tl_d    = tl_q;
        tcon_d  = tcon_q;
        presc_d = presc_q;
        pc_d    = pc_q + 16'd1;

        if (we_th_i) begin
            th_d = wdata_i[W-1:0];
        end
        if (we_presc_i) begin
            presc_d = wdata_i[15:0];
        end
        if (we_tcon_i) begin
            tcon_d = wdata_i[2:0];
        end else if (clear_en_ack_i) begin
            tcon_d[TCON_EN] = 1'b0;
        end
        // Reload reads th_q, so a TH write on the overflow edge applies next time
        if (we_tl_i) begin
            tl_d = wdata_i[W-1:0];
        end else if (tick) begin
            tl_d = (tl_q == '1) ? th_q : tl_q + W'(1);
        end
        if (!tcon_q[TCON_EN] || tick || we_presc_i || we_tcon_i) begin
            pc_d = '0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            th_q    <= LoadRst;
            tl_q    <= LoadRst;
            tcon_q  <= '0;
            presc_q <= '0;
            pc_q    <= '0;
        end else begin
            th_q    <= th_d;
            tl_q    <= tl_d;
            tcon_q  <= tcon_d;
            presc_q <= presc_d;
            pc_q    <= pc_d;
        end
    end

endmodule

// File: rtl/mmio_timer_array.sv
// Memory-mapped bank of N_CH timers with shared pending/mask registers
// aggregated onto a single registered interrupt line.
module mmio_timer_array
    import timer_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned W          = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
    parameter logic [31:0] RESET_LOAD = 32'hFFFF_F800
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    input  logic        MemRd,
    input  logic        MemWr,
    output logic [31:0] ReadData,
    output logic        inter
);

    localparam logic [31:0] GOff = 32'(CH_STRIDE * N_CH);

    logic [31:0]     off;
    logic            aligned, in_ch, sel_status, sel_mask;
    logic [3:0]      reg_off;
    logic [N_CH-1:0] ch_hit, ovf, ie_vec, os_vec;
    logic [N_CH-1:0] we_th, we_tl, we_tcon, we_presc, clr_en;
    logic [W-1:0]    th [N_CH];
    logic [W-1:0]    tl [N_CH];
    logic [2:0]      ctl [N_CH];
    logic [15:0]     presc [N_CH];

    logic [N_CH-1:0] status_q, status_d, mask_q, w1c;
    logic            inter_q;

    assign off        = Addr - BASE_ADDR;
    assign aligned    = (off[1:0] == 2'b00);
    assign in_ch      = aligned && (off < GOff);
    assign reg_off    = off[3:0];
    assign sel_status = aligned && (off == GOff + 32'(OFF_IRQ_STATUS));
    assign sel_mask   = aligned && (off == GOff + 32'(OFF_IRQ_MASK));

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign ch_hit[c]   = in_ch && (off[31:4] == 28'(c));
        assign we_th[c]    = MemWr && ch_hit[c] && (reg_off == OFF_TH);
        assign we_tl[c]    = MemWr && ch_hit[c] && (reg_off == OFF_TL);
        assign we_tcon[c]  = MemWr && ch_hit[c] && (reg_off == OFF_TCON);
        assign we_presc[c] = MemWr && ch_hit[c] && (reg_off == OFF_PRESC);
        assign ie_vec[c]   = ctl[c][TCON_IE];
        assign os_vec[c]   = ctl[c][TCON_ONESHOT];
        // One-shot channels drop EN on their own overflow
        assign clr_en[c]   = ovf[c] && os_vec[c];

        timer_channel #(
            .W          (W),
            .RESET_LOAD (RESET_LOAD)
        ) u_ch (
            .clk_i          (clk),
            .reset_i        (reset),
            .wdata_i        (WriteData),
            .we_th_i        (we_th[c]),
            .we_tl_i        (we_tl[c]),
            .we_tcon_i      (we_tcon[c]),
            .we_presc_i     (we_presc[c]),
            .clear_en_ack_i (clr_en[c]),
            .th_o           (th[c]),
            .tl_o           (tl[c]),
            .tcon_o         (ctl[c]),
            .presc_o        (presc[c]),
            .ovf_irq_o      (ovf[c])
        );
    end

    // Pending bits: write-1-to-clear, but a same-cycle overflow set wins
    always_comb begin
        w1c      = (MemWr && sel_status) ? WriteData[N_CH-1:0] : '0;
        status_d = (status_q & ~w1c) | (ovf & ie_vec);
    end

    // Global registers and the registered interrupt line
    always_ff @(posedge clk) begin
        if (reset) begin
            status_q <= '0;
            mask_q   <= '0;
            inter_q  <= 1'b0;
        end else begin
            status_q <= status_d;
            if (MemWr && sel_mask) begin
                mask_q <= WriteData[N_CH-1:0];
            end
            inter_q <= |(status_q & mask_q);
        end
    end

    assign inter = inter_q;

    // Combinational read mux; unmapped or idle reads return zero
    always_comb begin
        ReadData = '0;
        if (MemRd) begin
            if (sel_status) begin
                ReadData[N_CH-1:0] = status_q;
            end else if (sel_mask) begin
                ReadData[N_CH-1:0] = mask_q;
            end else begin
                for (int c = 0; c < N_CH; c++) begin
                    if (ch_hit[c]) begin
                        case (reg_off)
                            OFF_TH:    ReadData[W-1:0] = th[c];
                            OFF_TL:    ReadData[W-1:0] = tl[c];
                            OFF_TCON: begin
                                ReadData[2:0]       = ctl[c];
                                ReadData[TCON_PEND] = status_q[c];
                            end
                            OFF_PRESC: ReadData[15:0] = presc[c];
                            default:   ReadData = '0;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mmio_timer_array.sv
// Directed bench for mmio_timer_array with hand-computed expectations.
module tb_mmio_timer_array;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] G    = BASE + 32'h40;
    localparam logic [3:0]  RTH  = 4'h0;
    localparam logic [3:0]  RTL  = 4'h4;
    localparam logic [3:0]  RTC  = 4'h8;
    localparam logic [3:0]  RPS  = 4'hC;
    localparam logic [31:0] RST  = 32'hFFFF_F800;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Addr = '0;
    logic [31:0] WriteData = '0;
    logic        MemRd = 1'b0;
    logic        MemWr = 1'b0;
    logic [31:0] ReadData;
    logic        inter;

    int n_chk = 0;
    int n_fail = 0;

    mmio_timer_array dut (
        .clk       (clk),
        .reset     (reset),
        .Addr      (Addr),
        .WriteData (WriteData),
        .MemRd     (MemRd),
        .MemWr     (MemWr),
        .ReadData  (ReadData),
        .inter     (inter)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ca(input int c, input logic [3:0] o);
        return BASE + 32'(c) * 32'd16 + {28'd0, o};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rchk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        Addr  = a;
        MemRd = 1'b1;
        #1;
        d     = ReadData;
        MemRd = 1'b0;
        chk(tag, d, exp);
    endtask

    task automatic ichk(input string tag, input logic exp);
        chk(tag, {31'd0, inter}, {31'd0, exp});
    endtask

    // Write lands on the next rising edge; returns 1ns after that edge
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        Addr      = a;
        WriteData = d;
        MemWr     = 1'b1;
        @(posedge clk);
        #1;
        MemWr = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            rchk("rst_th", ca(c, RTH), RST);
            rchk("rst_tl", ca(c, RTL), RST);
            rchk("rst_tcon", ca(c, RTC), 32'h0);
            rchk("rst_presc", ca(c, RPS), 32'h0);
        end
        rchk("rst_status", G, 32'h0);
        rchk("rst_mask", G + 32'h4, 32'h0);
        rchk("unmapped_100", BASE + 32'h100, 32'h0);
        ichk("rst_inter", 1'b0);

        // Auto-reload on ch0: overflow 4 clocks after enable, period 4
        wr(ca(0, RTH), 32'hFFFF_FFFC);
        wr(ca(0, RTL), 32'hFFFF_FFFC);
        wr(G + 32'h4, 32'h1);
        wr(ca(0, RTC), 32'h3);
        for (int k = 0; k < 9; k++) begin
            rchk("ar_tl", ca(0, RTL), 32'hFFFF_FFFC + 32'(k % 4));
            if (k == 3) begin
                rchk("ar_status_pre", G, 32'h0);
                ichk("ar_inter_pre", 1'b0);
            end
            if (k == 4) begin
                rchk("ar_status_ovf", G, 32'h1);
                ichk("ar_inter_lag", 1'b0);
            end
            if (k == 5) ichk("ar_inter_up", 1'b1);
            step();
        end
        wr(ca(0, RTC), 32'h0);
        rchk("ar_pend_kept", ca(0, RTC), 32'h8);

        // Prescaler 3 with one-shot on ch2
        wr(ca(2, RPS), 32'h3);
        wr(ca(2, RTH), 32'hFFFF_FFFE);
        wr(ca(2, RTL), 32'hFFFF_FFFE);
        wr(ca(2, RTC), 32'h7);
        for (int k = 0; k < 12; k++) begin
            rchk("ps_tl", ca(2, RTL), (k >= 4 && k < 8) ? 32'hFFFF_FFFF : 32'hFFFF_FFFE);
            if (k == 7) rchk("ps_tcon_run", ca(2, RTC), 32'h7);
            if (k == 8) begin
                rchk("ps_tcon_done", ca(2, RTC), 32'hE);
                rchk("ps_status", G, 32'h5);
            end
            step();
        end

        // ch1 overflows every clock; W1C on an overflow edge must not clear
        wr(G + 32'h4, 32'h2);
        wr(ca(1, RTH), 32'hFFFF_FFFF);
        wr(ca(1, RTL), 32'hFFFF_FFFF);
        wr(ca(1, RTC), 32'h3);
        step();
        rchk("col_pending", G, 32'h7);
        wr(G, 32'h2);
        rchk("col_set_wins", G, 32'h7);
        // TH written on an overflow edge: old TH reloads, new TH next overflow
        wr(ca(1, RTH), 32'h0000_0010);
        rchk("th_old_reload", ca(1, RTL), 32'hFFFF_FFFF);
        step();
        rchk("th_new_reload", ca(1, RTL), 32'h0000_0010);
        wr(G, 32'h2);
        rchk("col_cleared", G, 32'h5);
        ichk("col_inter_hold", 1'b1);
        step();
        ichk("col_inter_fall", 1'b0);

        // Masking: ch0 and ch3 pending, only ch0 unmasked
        wr(ca(3, RTH), 32'hFFFF_FFFF);
        wr(ca(3, RTL), 32'hFFFF_FFFF);
        wr(ca(3, RTC), 32'h7);
        wr(G, 32'h4);
        wr(G + 32'h4, 32'h1);
        step();
        rchk("mk_status", G, 32'h9);
        rchk("mk_tcon3", ca(3, RTC), 32'hE);
        ichk("mk_inter_on", 1'b1);
        wr(G, 32'h1);
        step();
        ichk("mk_inter_off", 1'b0);
        rchk("mk_status_left", G, 32'h8);
        rchk("mk_mask", G + 32'h4, 32'h1);
        rchk("unmapped_g8", G + 32'h8, 32'h0);
        Addr = G;
        #1;
        chk("rd_idle_zero", ReadData, 32'h0);

        // TL write on a tick edge wins over the increment
        wr(ca(0, RTL), 32'h0000_0100);
        wr(ca(0, RTC), 32'h1);
        step();
        step();
        rchk("cnt_tl", ca(0, RTL), 32'h0000_0102);
        wr(ca(0, RTL), 32'h1234_5678);
        rchk("tl_wr_wins", ca(0, RTL), 32'h1234_5678);
        step();
        rchk("tl_wr_next", ca(0, RTL), 32'h1234_5679);

        // Reset asserted mid-count
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        rchk("mid_th0", ca(0, RTH), RST);
        rchk("mid_tl0", ca(0, RTL), RST);
        rchk("mid_tcon0", ca(0, RTC), 32'h0);
        rchk("mid_th1", ca(1, RTH), RST);
        rchk("mid_presc2", ca(2, RPS), 32'h0);
        rchk("mid_tcon2", ca(2, RTC), 32'h0);
        rchk("mid_status", G, 32'h0);
        rchk("mid_mask", G + 32'h4, 32'h0);
        ichk("mid_inter", 1'b0);
        step();
        rchk("mid_tl0_idle", ca(0, RTL), RST);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_timer_array.md
# mmio_timer_array

Parametrised memory-mapped timer bank on the CPU data bus, alongside the RAM, LED, 7-segment and UART registers in the peripheral address space. Provides N_CH independent up-counting timers. Each has a reload register, a prescaler, auto-reload or one-shot mode and a per-channel interrupt. A shared pending/mask register pair is aggregated onto a single CPU interrupt line.

## Interface
- N_CH, 4: number of timer channels, 1..8
- W, 32: counter/reload width, 8..32; register reads zero-extend to 32 bits
- BASE_ADDR, 32'h4000_0000: byte address of channel 0; word-aligned
- RESET_LOAD, 32'hFFFF_F800: reset value of every TH and TL, truncated to W
- clk  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high reset
- Addr  in  32  byte address from the CPU data path
- WriteData  in  32  store data
- MemRd  in  1  load strobe
- MemWr  in  1  store strobe
- ReadData  out  32  load data
- inter  out  1  OR of (IRQ_STATUS & IRQ_MASK), registered

## Operation
- Register map:
  - Channel c occupies BASE_ADDR + 16·c:
    - +0x0 TH (reload)
    - +0x4 TL (count)
    - +0x8 TCON
    - +0xC PRESC, bits [15:0]
  - Globals at G = BASE_ADDR + 16·N_CH:
    - G+0x0 IRQ_STATUS: bits [N_CH-1:0], write-1-to-clear
    - G+0x4 IRQ_MASK: bits [N_CH-1:0], read/write
  - Any other address is unmapped: writes are ignored, reads return 0.
- TCON bits:
  - [0] EN
  - [1] IE
  - [2] ONESHOT
  - [3] read-only copy of the channel's IRQ_STATUS bit
  - Bits [31:4] read as 0.
- Prescaler: each channel has a prescale counter PC. While EN=1 it counts 0..PRESC and produces a one-cycle tick when PC==PRESC, then returns to 0. PRESC=0 gives a tick every clock. PC is cleared on any write to PRESC or TCON, and whenever EN=0.
- On a tick:
  - If TL != all-ones, TL <= TL+1.
  - If TL == all-ones (overflow): TL <= TH; if IE=1, the channel's IRQ_STATUS bit is set; if ONESHOT=1, EN is cleared.
- Reads are combinational. ReadData=0 when MemRd=0. Reads have no side effects.
- Reset values:
  - TH = TL = RESET_LOAD
  - TCON, PRESC, PC, IRQ_STATUS, IRQ_MASK = 0
  - inter = 0
- Simultaneous events, priority within one channel per cycle:
  - A CPU write to TL beats the count/reload update on the same cycle.
  - A CPU write to TCON beats the one-shot EN clear on the same cycle.
  - A write to TH during an overflow: the reload uses the old TH; the new TH takes effect from the next cycle.
  - A W1C clear and a new overflow set on the same bit in the same cycle: the bit stays 1 (set wins).
  - Clearing IE does not clear an already-pending status bit.
- Reset mid-count: all state returns to reset values on the next edge. No interrupt is produced from an overflow in the same cycle as reset.

## Timing
- Register writes take effect at the clk edge where MemWr=1. Readback is visible in the following cycle.
- Counting latency: with EN written at edge t and PRESC=p, the first TL increment happens at edge t+p+1. Subsequent increments occur every p+1 edges.
- Overflow sets IRQ_STATUS at the tick edge; inter rises one edge later.
- Auto-reload period in clocks: (PRESC+1)·(2^W − TH).
- A W1C write at edge t drops inter at edge t+1, provided there are no other pending masked bits.

## Structure
- Package timer_pkg holds:
  - register offsets: OFF_TH, OFF_TL, OFF_TCON, OFF_PRESC, OFF_IRQ_STATUS, OFF_IRQ_MASK
  - TCON bit indices: TCON_EN, TCON_IE, TCON_ONESHOT, TCON_PEND
  - channel stride: CH_STRIDE = 16
- Sub-module timer_channel (parameter W) holds TH, TL, TCON bits [2:0], PRESC and PC for one channel.
  - Inputs: per-register write strobes, write data, and clear_en_ack.
  - Outputs: register values and an ovf_irq pulse.
- Top level contains:
  - address decode
  - a generate loop of N_CH timer_channel instances
  - IRQ_STATUS and IRQ_MASK
  - the read mux
  - the inter register

## Test plan
- Reset values: after reset, read every register of every channel. Expect TH=TL=32'hFFFF_F800, all others 0, inter=0. Unmapped reads (BASE_ADDR+0x100) return 0.
- Auto-reload:
  - Setup: ch0 with TH=TL=32'hFFFF_FFFC, PRESC=0, TCON=3'b011, IRQ_MASK=1.
  - Expect overflow 4 clocks after the enable, then inter=1 on the next edge.
  - Expect TL=32'hFFFF_FFFC after reload.
  - Expect a period of 4 clocks thereafter.
- Prescaler and one-shot:
  - Setup: ch2 with PRESC=3, TH=TL=32'hFFFF_FFFE, TCON=3'b111.
  - Expect TL increments every 4 clocks.
  - Expect overflow at the 8th clock, then EN reads 0 and TL holds at 32'hFFFF_FFFE.
- W1C/overflow collision:
  - Setup: ch1 pending.
  - Action: write IRQ_STATUS=2 on the same edge that ch1 overflows again.
  - Expect the bit to remain 1; a later W1C clears it and inter falls one edge after.
- Masking and aggregation:
  - Setup: ch0 and ch3 both pending, IRQ_MASK=4'b0001.
  - Expect inter=1. Clear bit 0 and expect inter=0 while IRQ_STATUS still reads 4'b1000.
- Write priority:
  - A TL write coincident with a tick: TL equals the written value.
  - Reset asserted mid-count: all registers return to reset values on the next edge.
